rgb_pwm: RTL and testbench
==========================

Name: rgb_pwm

Overview:
- Three-channel PWM generator that drives an RGB LED.
- Sits directly downstream of the controlled up/down counter. The counter's value output feeds one duty input, so buttons step LED brightness.
- Advances on the same prescaler tick (clock_enable) that the counter uses.
- Duties are double-buffered and update only at a period boundary, so the outputs never glitch.

Parameters:
- DUTY_WIDTH, default 4: width of each duty input and of the phase counter. Matches the default counter width.
- ACTIVE_LOW, default 0: when 1, led_* outputs are inverted for common-anode LEDs.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- clock_enable, input, 1: one-cycle prescaler tick; phase advances only on ticks.
- enable, input, 1: 0 forces all LEDs off and holds phase at 0.
- duty_r, input, DUTY_WIDTH: red duty, in ticks per period.
- duty_g, input, DUTY_WIDTH: green duty.
- duty_b, input, DUTY_WIDTH: blue duty.
- led_r, output, 1: red PWM output, registered.
- led_g, output, 1: green PWM output, registered.
- led_b, output, 1: blue PWM output, registered.
- period_start, output, 1: one-clock pulse when a new period begins.

Behaviour:
- Reset is synchronous and active-high on clock.
  - Reset values: phase=0, all shadow duties=0, period_start=0.
  - led_* reset to the off level: 0 if ACTIVE_LOW=0, 1 if ACTIVE_LOW=1.
  - Reset mid-period aborts the period immediately; the next period starts from phase 0.
- Phase counter:
  - Range 0..PMAX, where PMAX = 2^DUTY_WIDTH - 2. The period is 2^DUTY_WIDTH - 1 ticks (15 at default width).
  - On clock_enable=1: if phase==PMAX, phase goes to 0 (wrap); otherwise phase increments.
  - On clock_enable=0: phase holds.
- Shadow duties:
  - shadow_x loads from duty_x on the same edge that phase wraps to 0.
  - Duty changes mid-period take effect only in the next period.
- Compare, per channel: on = (phase < shadow_x), unsigned, DUTY_WIDTH-bit.
  - duty=0 gives constant off.
  - duty=2^DUTY_WIDTH-1 gives constant on (100%).
  - Duty d gives exactly d ticks on per period.
- Output: led_x <= (enable & on_x) XOR ACTIVE_LOW, registered. Output lags phase by 1 clock.
- period_start: registered, 1 for exactly one clock on the edge after the wrap edge. It is aligned with the first led_* update of the new period.
- enable=0:
  - phase forced to 0; shadows load from duty_* every clock; period_start=0; led_* at the off level from the next clock.
  - On the enable 0→1 edge, a period begins at phase 0 with the current duties. period_start is not pulsed for this first period.
- Simultaneous events:
  - reset has priority over everything.
  - enable=0 has priority over clock_enable.
  - A wrap and a duty change in the same cycle load the new duty.
- No handshake; duty inputs are sampled, not acknowledged.

Decomposition:
- Package rgb_pkg:
  - typedef duty_t (logic [DUTY_WIDTH-1:0]).
  - typedef struct rgb_duty_t {r,g,b}.
  - localparam function for PMAX.
- Sub-module pwm_channel: one shadow register, comparator, and registered output with polarity. It is instantiated three times; rgb_pwm owns the phase counter and period_start.

Test Plan (DUTY_WIDTH=4, ACTIVE_LOW=0, clock_enable high every 4th clock unless stated):
- Reset, then enable=1, duties r=0, g=15, b=7 for 3 periods -> led_r always 0, led_g always 1, led_b high exactly 7 of 15 ticks each period; period_start pulses every 60 clocks.
- Change duty_r from 3 to 10 at phase 5 -> current period still shows 3 ticks high; next period shows 10 ticks high; no glitch pulse.
- clock_enable tied high, duty_b=1 -> led_b high for 1 clock in every 15, one clock after period_start-aligned phase 0.
- Drop enable to 0 mid-period, then reassert -> all led_* 0 within 1 clock; on re-enable, phase restarts at 0 with the current duties; no period_start on the first period.
- Assert reset at phase 9 with duty_g=12 -> led_* 0 and period_start 0 next clock; after release, full periods restart from phase 0 with shadow loaded at the first wrap.
- ACTIVE_LOW=1, duty_r=0 -> led_r constant 1; during and after reset all led_* read 1.

Source files
------------

// File: rtl/rgb_pwm_pkg.sv
// rgb_pkg: shared types and helpers for the rgb_pwm block.
//   duty_t      - one channel duty value at the default width
//   rgb_duty_t  - bundled r/g/b duty values
//   pmax()      - last phase value of a period for a given duty width
package rgb_pkg;

   localparam int unsigned DEFAULT_DUTY_WIDTH = 4;

   typedef logic [DEFAULT_DUTY_WIDTH-1:0] duty_t;

   typedef struct packed {
      duty_t r;
      duty_t g;
      duty_t b;
   } rgb_duty_t;

   // Period is 2^w - 1 ticks, so the phase runs 0 .. 2^w - 2 and a duty of
   // all-ones stays on for the whole period.
   function automatic int unsigned pmax(input int unsigned w);
      return (32'd1 << w) - 32'd2;
   endfunction

endpackage

// File: rtl/rgb_pwm_if.sv
// rgb_pwm_if: control and output bundle of the RGB PWM generator.
//   clock_enable       - prescaler tick, phase advances only on ticks
//   enable             - 0 forces LEDs off and holds phase at 0
//   duty_r/g/b         - per-channel duty in ticks per period
//   led_r/g/b          - registered PWM outputs
//   period_start       - one-clock pulse at the start of each period
// master: the controller driving duties; slave: the PWM generator.
interface rgb_pwm_if #(
   parameter int unsigned DUTY_WIDTH = 4
);
   logic                  clock_enable;
   logic                  enable;
   logic [DUTY_WIDTH-1:0] duty_r;
   logic [DUTY_WIDTH-1:0] duty_g;
   logic [DUTY_WIDTH-1:0] duty_b;
   logic                  led_r;
   logic                  led_g;
   logic                  led_b;
   logic                  period_start;

   modport master (
      output clock_enable, enable, duty_r, duty_g, duty_b,
      input  led_r, led_g, led_b, period_start
   );

   modport slave (
      input  clock_enable, enable, duty_r, duty_g, duty_b,
      output led_r, led_g, led_b, period_start
   );
endinterface

// File: rtl/rgb_pwm_channel.sv
// pwm_channel: one PWM channel of rgb_pwm.
//   clock, reset - system clock, synchronous active-high reset
//   load         - shadow register load strobe (period boundary or disabled)
//   enable       - 0 drives the output to the off level
//   duty         - requested duty, captured into the shadow on load
//   phase        - shared phase counter from rgb_pwm
//   led          - registered output, inverted when ACTIVE_LOW=1
module pwm_channel #(
   parameter int unsigned DUTY_WIDTH = 4,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  enable,
   input  logic [DUTY_WIDTH-1:0] duty,
   input  logic [DUTY_WIDTH-1:0] phase,
   output logic                  led
);

   logic [DUTY_WIDTH-1:0] shadow;
   logic                  on;

   always_comb begin
      on = (phase < shadow);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         shadow <= '0;
         led    <= ACTIVE_LOW;
      end else begin
         if (load) begin
            shadow <= duty;
         end
         led <= (enable & on) ^ ACTIVE_LOW;
      end
   end

endmodule

// File: rtl/rgb_pwm.sv
// rgb_pwm: three-channel PWM generator for an RGB LED.
//   clock, reset - system clock, synchronous active-high reset
//   bus (slave)  - clock_enable, enable, duty_r/g/b in;
//                  led_r/g/b, period_start out
// Owns the shared phase counter and period_start; each colour is a
// pwm_channel with its own double-buffered duty.
module rgb_pwm
   import rgb_pkg::*;
#(
   parameter int unsigned DUTY_WIDTH = 4,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic     clock,
   input  logic     reset,
   rgb_pwm_if.slave bus
);

   localparam logic [DUTY_WIDTH-1:0] PMAX = DUTY_WIDTH'(pmax(DUTY_WIDTH));

   logic [DUTY_WIDTH-1:0] phase;
   logic                  wrap;
   logic                  load;
   logic                  wrap_q;
   logic                  period_start_q;
   logic                  led_r;
   logic                  led_g;
   logic                  led_b;

   always_comb begin
      wrap = bus.enable & bus.clock_enable & (phase == PMAX);
      // While disabled the shadows track the inputs so re-enable starts
      // with the current duties.
      load = ~bus.enable | wrap;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         phase          <= '0;
         wrap_q         <= 1'b0;
         period_start_q <= 1'b0;
      end else begin
         if (!bus.enable) begin
            phase <= '0;
         end else if (bus.clock_enable) begin
            phase <= (phase == PMAX) ? '0 : phase + DUTY_WIDTH'(1);
         end
         wrap_q <= wrap;
         // Delayed one extra clock so the pulse lines up with the first
         // LED update computed from phase 0.
         period_start_q <= bus.enable & wrap_q;
      end
   end

   pwm_channel #(.DUTY_WIDTH(DUTY_WIDTH), .ACTIVE_LOW(ACTIVE_LOW)) u_red (
      .clock  (clock),
      .reset  (reset),
      .load   (load),
      .enable (bus.enable),
      .duty   (bus.duty_r),
      .phase  (phase),
      .led    (led_r)
   );

   pwm_channel #(.DUTY_WIDTH(DUTY_WIDTH), .ACTIVE_LOW(ACTIVE_LOW)) u_green (
      .clock  (clock),
      .reset  (reset),
      .load   (load),
      .enable (bus.enable),
      .duty   (bus.duty_g),
      .phase  (phase),
      .led    (led_g)
   );

   pwm_channel #(.DUTY_WIDTH(DUTY_WIDTH), .ACTIVE_LOW(ACTIVE_LOW)) u_blue (
      .clock  (clock),
      .reset  (reset),
      .load   (load),
      .enable (bus.enable),
      .duty   (bus.duty_b),
      .phase  (phase),
      .led    (led_b)
   );

   assign bus.led_r        = led_r;
   assign bus.led_g        = led_g;
   assign bus.led_b        = led_b;
   assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_rgb_pwm.sv
// tb_rgb_pwm: directed bench for rgb_pwm. Two DUTs (ACTIVE_LOW 0 and 1)
// share one stimulus; a period-level model predicts outputs every clock,
// and literal per-period counts pin the model.
module tb_rgb_pwm;
   import rgb_pkg::*;

   localparam int W      = 4;
   localparam int PERIOD = (1 << W) - 1;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   rgb_pwm_if #(.DUTY_WIDTH(W)) bus0 ();
   rgb_pwm_if #(.DUTY_WIDTH(W)) bus1 ();

   assign bus1.clock_enable = bus0.clock_enable;
   assign bus1.enable       = bus0.enable;
   assign bus1.duty_r       = bus0.duty_r;
   assign bus1.duty_g       = bus0.duty_g;
   assign bus1.duty_b       = bus0.duty_b;

   rgb_pwm #(.DUTY_WIDTH(W), .ACTIVE_LOW(1'b0)) dut_hi (
      .clock (clock),
      .reset (reset),
      .bus   (bus0)
   );

   rgb_pwm #(.DUTY_WIDTH(W), .ACTIVE_LOW(1'b1)) dut_lo (
      .clock (clock),
      .reset (reset),
      .bus   (bus1)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit ce_tied     = 1'b0;
   bit model_valid = 1'b0;

   task automatic check(input string name, input logic [2:0] got, input logic [2:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%b want=%b at t=%0t", name, got, want, $time);
      end
   endtask

   // Prescaler tick: every 4th clock unless tied high.
   initial begin
      bus0.clock_enable = 1'b0;
      forever begin
         @(negedge clock);
         cyc++;
         bus0.clock_enable = ce_tied ? 1'b1 : ((cyc % 4) == 0);
      end
   end

   // Model: position within the period in ticks and the duties latched
   // for that period; outputs after an edge reflect the state before it.
   int pos;
   int lat[3];
   bit exp_led[3];
   bit exp_ps;
   bit pend;

   function automatic int duty_in(input int c);
      case (c)
         0:       return int'(bus0.duty_r);
         1:       return int'(bus0.duty_g);
         default: return int'(bus0.duty_b);
      endcase
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         pos    = 0;
         pend   = 1'b0;
         exp_ps = 1'b0;
         for (int c = 0; c < 3; c++) begin
            lat[c]     = 0;
            exp_led[c] = 1'b0;
         end
         model_valid = 1'b1;
      end else begin
         for (int c = 0; c < 3; c++) exp_led[c] = bus0.enable && (pos < lat[c]);
         exp_ps = bus0.enable && pend;
         pend   = 1'b0;
         if (!bus0.enable) begin
            pos = 0;
            for (int c = 0; c < 3; c++) lat[c] = duty_in(c);
         end else if (bus0.clock_enable) begin
            if (pos == PERIOD - 1) begin
               pos  = 0;
               pend = 1'b1;
               for (int c = 0; c < 3; c++) lat[c] = duty_in(c);
            end else begin
               pos++;
            end
         end
      end
   end

   always @(negedge clock) begin
      if (model_valid) begin
         check("led", {bus0.led_r, bus0.led_g, bus0.led_b},
               {exp_led[0], exp_led[1], exp_led[2]});
         check("led_al", {bus1.led_r, bus1.led_g, bus1.led_b},
               ~{exp_led[0], exp_led[1], exp_led[2]});
         check("ps", {2'b00, bus0.period_start}, {2'b00, exp_ps});
         check("ps_al", {2'b00, bus1.period_start}, {2'b00, exp_ps});
      end
   end

   // Waits for period_start, then counts LED-high clocks over one period
   // (from this pulse up to the next). Optionally changes duty_r mid-way.
   task automatic measure(input int chg_at, input int chg_val,
                          output int hr, output int hg, output int hb,
                          output int len, output bit b0);
      bit got;
      hr = 0; hg = 0; hb = 0; len = 0; b0 = 1'b0; got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (bus0.period_start) begin
            got = 1'b1;
            break;
         end
         @(negedge clock);
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL ps_timeout got=none want=pulse at t=%0t", $time);
         return;
      end
      b0 = bus0.led_b;
      for (int i = 0; i < 300; i++) begin
         if (i == chg_at) bus0.duty_r = W'(chg_val);
         hr  += int'(bus0.led_r);
         hg  += int'(bus0.led_g);
         hb  += int'(bus0.led_b);
         len++;
         @(negedge clock);
         if (bus0.period_start) break;
      end
   endtask

   task automatic check_int(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at t=%0t", name, got, want, $time);
      end
   endtask

   int hr, hg, hb, len, cnt, pcnt;
   bit b0;

   initial begin
      bus0.enable = 1'b0;
      bus0.duty_r = 4'd0;
      bus0.duty_g = 4'd15;
      bus0.duty_b = 4'd7;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_led", {bus0.led_r, bus0.led_g, bus0.led_b}, 3'b000);
      check("rst_led_al", {bus1.led_r, bus1.led_g, bus1.led_b}, 3'b111);
      check("rst_ps", {2'b00, bus0.period_start}, 3'b000);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      bus0.enable = 1'b1;

      // r=0, g=15, b=7 over three periods
      for (int p = 0; p < 3; p++) begin
         measure(-1, 0, hr, hg, hb, len, b0);
         check_int("a_len", len, 60);
         check_int("a_r", hr, 0);
         check_int("a_g", hg, 60);
         check_int("a_b", hb, 28);
      end
      check("a_al_r", {2'b00, bus1.led_r}, 3'b001);

      // duty_r 3 -> 10 at phase 5 lands in the following period
      bus0.duty_r = 4'd3;
      measure(-1, 0, hr, hg, hb, len, b0);
      check_int("b_pre_r", hr, 0);
      measure(20, 10, hr, hg, hb, len, b0);
      check_int("b_cur_r", hr, 12);
      measure(-1, 0, hr, hg, hb, len, b0);
      check_int("b_next_r", hr, 40);

      // clock_enable tied high, duty_b=1
      ce_tied = 1'b1;
      bus0.duty_b = 4'd1;
      measure(-1, 0, hr, hg, hb, len, b0);
      measure(-1, 0, hr, hg, hb, len, b0);
      check_int("c_len", len, 15);
      check_int("c_b", hb, 1);
      check_int("c_b_at_start", int'(b0), 1);

      // enable drop mid-period and re-enable
      ce_tied = 1'b0;
      measure(-1, 0, hr, hg, hb, len, b0);
      repeat (20) @(negedge clock);
      bus0.enable = 1'b0;
      @(negedge clock);
      check("d_off", {bus0.led_r, bus0.led_g, bus0.led_b}, 3'b000);
      repeat (3) @(negedge clock);
      bus0.duty_r = 4'd5;
      bus0.duty_g = 4'd15;
      bus0.duty_b = 4'd2;
      @(negedge clock);
      bus0.enable = 1'b1;
      @(negedge clock);
      check("d_reen", {bus0.led_r, bus0.led_g, bus0.led_b}, 3'b111);
      pcnt = 0;
      for (int i = 0; i < 40; i++) begin
         pcnt += int'(bus0.period_start);
         @(negedge clock);
      end
      check_int("d_no_ps", pcnt, 0);
      measure(-1, 0, hr, hg, hb, len, b0);
      check_int("d_r", hr, 20);
      check_int("d_b", hb, 8);

      // reset at phase 9 with duty_g=12
      bus0.duty_g = 4'd12;
      measure(-1, 0, hr, hg, hb, len, b0);
      check_int("e_pre_g", hg, 60);
      repeat (35) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("e_rst_led", {bus0.led_r, bus0.led_g, bus0.led_b}, 3'b000);
      check("e_rst_led_al", {bus1.led_r, bus1.led_g, bus1.led_b}, 3'b111);
      check("e_rst_ps", {2'b00, bus0.period_start}, 3'b000);
      reset = 1'b0;
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (bus0.period_start) break;
         cnt += int'(bus0.led_g);
      end
      check_int("e_first_g", cnt, 0);
      measure(-1, 0, hr, hg, hb, len, b0);
      check_int("e_g", hg, 48);
      check_int("e_len", len, 60);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
